// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: memory-mapped 8N1 UART for the MEM-stage load/store bus.
// TXD at BASE_ADDR (write starts a frame), RXD at BASE_ADDR+4, CON at BASE_ADDR+8.
// Optional build macro UART_RX_FIFO_EN: RXD backed by a 4-entry receive FIFO
// instead of a single overwrite-on-arrival holding register.
module uart_mmio_responder #(
  parameter int          BAUD_DIV  = 10417,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irqout
);

  localparam int              CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [31:0]     RXD_ADDR  = BASE_ADDR + 32'd4;
  localparam logic [31:0]     CON_ADDR  = BASE_ADDR + 32'd8;

  // Bus decode: strobes qualify every side effect, so idle/unmapped cycles do nothing.
  logic txd_wr, rxd_rd, con_rd, con_wr;
  assign txd_wr = MemWr & (Address == BASE_ADDR);
  assign rxd_rd = MemRd & (Address == RXD_ADDR);
  assign con_rd = MemRd & (Address == CON_ADDR);
  assign con_wr = MemWr & (Address == CON_ADDR);

  // Only the low byte of store data is meaningful here.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, WriteData[31:8]};

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_q;
  logic             tx_bit_end, tx_end, tx_busy;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  assign tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
  assign tx_end     = (tx_state_q == TX_STOP) & tx_bit_end;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign uart_tx    = tx_q;

  // TX frame sequencer; writes arriving while busy fall through the IDLE-only accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          if (txd_wr) begin
            tx_shift_q <= WriteData[7:0];
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          tx_cnt_q <= tx_cnt_d;
          if (tx_bit_end) begin
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          tx_cnt_q <= tx_cnt_d;
          if (tx_bit_end) begin
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end
        end
        TX_STOP: begin
          tx_cnt_q <= tx_cnt_d;
          if (tx_bit_end) tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t        rx_state_q;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_bit_end, rx_half_end, rx_stop_smp, rx_good, rx_bad;

  assign rx_bit_end  = (rx_cnt_q == BIT_LAST);
  assign rx_half_end = (rx_cnt_q == HALF_LAST);
  assign rx_stop_smp = (rx_state_q == RX_STOP) & rx_bit_end;
  assign rx_good     = rx_stop_smp & rx_s2_q;
  assign rx_bad      = rx_stop_smp & ~rx_s2_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX frame sequencer; a bad stop parks in BREAK until the line returns high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q & ~rx_s2_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_half_end) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_BREAK;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_BREAK: if (rx_s2_q) rx_state_q <= RX_IDLE;
        default:  rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- receive data holding ----------------
  logic       rx_done, rx_ovr_evt;
  logic [7:0] rxd_data;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem_q [4];
  logic [1:0] fifo_wr_q, fifo_rd_q;
  logic [2:0] fifo_cnt_q;
  logic       fifo_full, fifo_push, fifo_pop;

  assign fifo_full  = (fifo_cnt_q == 3'd4);
  assign fifo_pop   = rxd_rd & (fifo_cnt_q != 3'd0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign fifo_push  = rx_good & (~fifo_full | fifo_pop);
  assign rx_ovr_evt = rx_good & fifo_full & ~fifo_pop;
  assign rx_done    = (fifo_cnt_q != 3'd0);
  assign rxd_data   = rx_done ? fifo_mem_q[fifo_rd_q] : 8'h00;

  // FIFO storage writes; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[fifo_wr_q] <= rx_shift_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) fifo_wr_q <= fifo_wr_q + 2'd1;
      if (fifo_pop)  fifo_rd_q <= fifo_rd_q + 2'd1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end
`else
  logic [7:0] rx_byte_q;
  logic       rx_done_q;

  // An RXD read in the arrival cycle still returns the old byte, so nothing is lost.
  assign rx_ovr_evt = rx_good & rx_done_q & ~rxd_rd;
  assign rx_done    = rx_done_q;
  assign rxd_data   = rx_byte_q;

  // Single holding register: new byte overwrites, arrival beats a same-cycle read clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte_q <= '0;
      rx_done_q <= 1'b0;
    end else if (rx_good) begin
      rx_byte_q <= rx_shift_q;
      rx_done_q <= 1'b1;
    end else if (rxd_rd) begin
      rx_done_q <= 1'b0;
    end
  end
`endif

  // ---------------- control/status and interrupt ----------------
  logic tx_irq_en_q, rx_irq_en_q, tx_done_q, overrun_q, frame_err_q, irq_q;
  assign irqout = irq_q;

  // Sticky flags: a set event always beats a same-cycle CON read clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (con_wr) {rx_irq_en_q, tx_irq_en_q} <= WriteData[1:0];
      if (tx_end)          tx_done_q   <= 1'b1;
      else if (con_rd)     tx_done_q   <= 1'b0;
      if (rx_ovr_evt)      overrun_q   <= 1'b1;
      else if (con_rd)     overrun_q   <= 1'b0;
      if (rx_bad)          frame_err_q <= 1'b1;
      else if (con_rd)     frame_err_q <= 1'b0;
      irq_q <= (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_done);
    end
  end

  // Load data path; zero unless a mapped readable register is addressed.
  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      if (Address == RXD_ADDR)
        ReadData = {24'b0, rxd_data};
      else if (Address == CON_ADDR)
        ReadData = {25'b0, frame_err_q, overrun_q, tx_busy, rx_done,
                    tx_done_q, rx_irq_en_q, tx_irq_en_q};
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Testbench for uart_mmio_responder (BAUD_DIV=16). Handles both builds of
// the UART_RX_FIFO_EN option.
module tb_uart_mmio_responder;

  localparam int          BD  = 16;
  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] RXD = 32'h4000001C;
  localparam logic [31:0] CON = 32'h40000020;

  logic        clk, reset, MemRd, MemWr, uart_rx, uart_tx, irqout;
  logic [31:0] Address, WriteData, ReadData;

  int   total, bad;
  int   seen_err;
  logic seen_done;
  logic [7:0] rx_sent [$];

  uart_mmio_responder #(.BAUD_DIV(BD), .BASE_ADDR(TXD)) dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int          op;    // 0 write, 1 read (with edge), 2 address only, MemRd low
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Combinational look with MemRd dropped before the next edge: no side effects.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRd   = 1'b1;
    #1;
    d     = ReadData;
    MemRd = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRd   = 1'b1;
    #1;
    d = ReadData;
    tick();
    MemRd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    Address   = a;
    WriteData = v;
    MemWr     = 1'b1;
    tick();
    MemWr = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Serial frame onto uart_rx; optionally sample CON each cycle (MemRd held by caller).
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit mon);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BD; c++) begin
        uart_rx = fr[i];
        if (mon) begin
          #1;
          if (ReadData[6]) seen_err++;
          seen_done = ReadData[3];
        end
        tick();
      end
    end
    uart_rx = 1'b1;
  endtask

  // Independent line decoder: mid-bit sampling of uart_tx.
  task automatic decode_tx(output logic [7:0] b, output bit ok);
    int w;
    ok = 1'b0;
    b  = '0;
    w  = 0;
    while (uart_tx !== 1'b0 && w < 400) begin
      tick();
      w++;
    end
    if (uart_tx === 1'b0) begin
      repeat (BD / 2) tick();
      for (int j = 0; j < 8; j++) begin
        repeat (BD) tick();
        b[j] = uart_tx;
      end
      repeat (BD) tick();
      ok = (uart_tx === 1'b1);
    end
  endtask

  // Store a byte and check the line cycle by cycle against the 10-bit frame.
  task automatic tx_run(input logic [7:0] b, input int drop_k, input bit chk_irq);
    logic [9:0]  fr;
    logic [31:0] d;
    logic        exp_bit;
    fr = {1'b1, b, 1'b0};
    bus_write(TXD, {24'b0, b});
    for (int k = 0; k < 162; k++) begin
      exp_bit = (k < 10 * BD) ? fr[k / BD] : 1'b1;
      check($sformatf("tx_line_k%0d", k), uart_tx, exp_bit);
      if (k == 0) begin
        peek(CON, d);
        check("tx_busy_start", d[4], 1'b1);
      end
      if (k == 10 * BD) begin
        peek(CON, d);
        check("tx_done_busy_end", d[4:2], 3'b001);
      end
      if (chk_irq && k == 10 * BD)     check("irq_not_yet", irqout, 1'b0);
      if (chk_irq && k == 10 * BD + 1) check("irq_raised", irqout, 1'b1);
      if (k == drop_k) begin
        Address   = TXD;
        WriteData = 32'h3C;
        MemWr     = 1'b1;
      end
      tick();
      MemWr = 1'b0;
    end
  endtask

  // Random TX byte in parallel with random RX bursts, checked against a queue model.
  task automatic run_random(input int iters);
    logic [7:0]  txb, got_b;
    logic [31:0] d, exp_con;
    bit          ok, exp_ovr;
    int          n, keep;
    for (int it = 0; it < iters; it++) begin
      rx_sent.delete();
      n   = $urandom_range(1, 5);
      txb = 8'($urandom);
      bus_write(TXD, {24'b0, txb});
      fork
        begin
          for (int i = 0; i < n; i++) begin
            logic [7:0] v;
            repeat ($urandom_range(0, 20)) tick();
            v = 8'($urandom);
            rx_sent.push_back(v);
            send_rx(v, 1'b1, 1'b0);
          end
        end
        decode_tx(got_b, ok);
      join
      repeat (20) tick();
      check($sformatf("rnd%0d_tx_frame_ok", it), ok, 1'b1);
      check($sformatf("rnd%0d_tx_byte", it), got_b, txb);
`ifdef UART_RX_FIFO_EN
      exp_ovr = (n > 4);
      keep    = (n > 4) ? 4 : n;
`else
      exp_ovr = (n > 1);
      keep    = 1;
`endif
      exp_con = 32'h0C | (exp_ovr ? 32'h20 : 32'h0);
      bus_read(CON, d);
      check($sformatf("rnd%0d_con", it), d, exp_con);
      for (int i = 0; i < keep; i++) begin
        bus_read(RXD, d);
`ifdef UART_RX_FIFO_EN
        check($sformatf("rnd%0d_rxd%0d", it, i), d, {24'b0, rx_sent[i]});
`else
        check($sformatf("rnd%0d_rxd%0d", it, i), d, {24'b0, rx_sent[n-1]});
`endif
      end
      peek(CON, d);
      check($sformatf("rnd%0d_con_clear", it), d, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        all_high;
    total = 0; bad = 0; seen_err = 0; seen_done = 1'b0;
    reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0;
    Address = '0; WriteData = '0; uart_rx = 1'b1;

    vecs[0]  = '{1, CON, 32'h0, 32'h0};
    vecs[1]  = '{1, RXD, 32'h0, 32'h0};
    vecs[2]  = '{1, TXD, 32'h0, 32'h0};
    vecs[3]  = '{0, CON, 32'h3, 32'h0};
    vecs[4]  = '{1, CON, 32'h0, 32'h3};
    vecs[5]  = '{2, CON, 32'h0, 32'h0};
    vecs[6]  = '{0, CON, 32'hFFFF_FFF6, 32'h0};
    vecs[7]  = '{1, CON, 32'h0, 32'h2};
    vecs[8]  = '{0, 32'h40000024, 32'h1, 32'h0};
    vecs[9]  = '{1, CON, 32'h0, 32'h2};
    vecs[10] = '{1, 32'h40000024, 32'h0, 32'h0};
    vecs[11] = '{1, 32'h40000014, 32'h0, 32'h0};
    vecs[12] = '{0, CON, 32'h0, 32'h0};
    vecs[13] = '{1, CON, 32'h0, 32'h0};

    // Reset state
    repeat (3) tick();
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_irqout", irqout, 1'b0);
    peek(CON, d);
    check("rst_con", d, 32'h0);
    reset = 1'b0;
    tick();

    // Register-map table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].op == 0) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else if (vecs[i].op == 1) begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end else begin
        Address = vecs[i].addr;
        MemRd   = 1'b0;
        #1;
        check($sformatf("vec%0d_rd_low", i), ReadData, vecs[i].exp);
      end
    end

    // TX 0xA5 with tx interrupt enabled
    bus_write(CON, 32'h1);
    tx_run(8'hA5, -1, 1'b1);
    bus_read(CON, d);
    check("tx_con_after", d, 32'h05);
    tick();
    check("irq_cleared", irqout, 1'b0);

    // Second store at cycle 50 is dropped
    bus_write(CON, 32'h0);
    tx_run(8'hA5, 50, 1'b0);
    bus_read(CON, d);
    check("tx_drop_con", d, 32'h04);
    all_high = 1'b1;
    repeat (200) begin
      if (uart_tx !== 1'b1) all_high = 1'b0;
      tick();
    end
    check("tx_no_second_frame", all_high, 1'b1);

    // Reset in the middle of a frame
    bus_write(TXD, 32'hA5);
    repeat (39) tick();
    peek(CON, d);
    check("mid_busy", d[4], 1'b1);
    tick();
    check("mid_line_low", uart_tx, 1'b0);
    #2 reset = 1'b1;
    #1 check("mid_rst_tx_high", uart_tx, 1'b1);
    Address = CON;
    MemRd   = 1'b1;
    #1 check("mid_rst_readdata", ReadData, 32'h0);
    MemRd = 1'b0;
    #1 reset = 1'b0;
    tick();
    bus_read(CON, d);
    check("mid_con_after", d, 32'h0);
    all_high = 1'b1;
    repeat (40) begin
      if (uart_tx !== 1'b1) all_high = 1'b0;
      tick();
    end
    check("mid_line_idle", all_high, 1'b1);

    // Receive 0x5A, read clears rx_done; short glitch ignored
    send_rx(8'h5A, 1'b1, 1'b0);
    repeat (4) tick();
    peek(CON, d);
    check("rx_done_set", d, 32'h08);
    bus_read(RXD, d);
    check("rx_byte_5a", d, 32'h5A);
    peek(CON, d);
    check("rx_done_cleared", d, 32'h0);
    uart_rx = 1'b0;
    tick();
    tick();
    uart_rx = 1'b1;
    repeat (40) tick();
    peek(CON, d);
    check("glitch_con", d, 32'h0);
    peek(RXD, d);
`ifdef UART_RX_FIFO_EN
    check("glitch_rxd", d, 32'h0);
`else
    check("glitch_rxd", d, 32'h5A);
`endif

    // Two unread bytes
    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    repeat (4) tick();
`ifdef UART_RX_FIFO_EN
    peek(CON, d);
    check("two_con", d, 32'h08);
    bus_read(RXD, d);
    check("two_rxd0", d, 32'h11);
    bus_read(RXD, d);
    check("two_rxd1", d, 32'h22);
    peek(CON, d);
    check("two_con_empty", d, 32'h0);
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, 1'b0);
    repeat (4) tick();
    peek(CON, d);
    check("five_con", d, 32'h28);
    for (int i = 1; i <= 4; i++) begin
      bus_read(RXD, d);
      check($sformatf("five_rxd%0d", i), d, i);
    end
    bus_read(CON, d);
    check("five_con_ovr", d, 32'h20);
`else
    peek(CON, d);
    check("two_con", d, 32'h28);
    bus_read(RXD, d);
    check("two_rxd", d, 32'h22);
    bus_read(CON, d);
    check("two_con_ovr", d, 32'h20);
`endif
    peek(CON, d);
    check("ovr_cleared", d, 32'h0);

    // Bad stop bit: frame_err, byte discarded
    send_rx(8'h33, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (10) tick();
    uart_rx = 1'b1;
    repeat (5) tick();
    peek(CON, d);
    check("ferr_con", d, 32'h40);
    peek(RXD, d);
`ifdef UART_RX_FIFO_EN
    check("ferr_rxd_kept", d, 32'h0);
`else
    check("ferr_rxd_kept", d, 32'h22);
`endif
    bus_read(CON, d);
    check("ferr_read", d, 32'h40);
    peek(CON, d);
    check("ferr_cleared", d, 32'h0);

    // Bad frame under continuous CON reads: flag visible exactly one cycle
    seen_err = 0;
    Address  = CON;
    MemRd    = 1'b1;
    send_rx(8'h44, 1'b0, 1'b1);
    MemRd   = 1'b0;
    uart_rx = 1'b0;
    repeat (10) tick();
    uart_rx = 1'b1;
    repeat (5) tick();
    check("ferr_set_wins", seen_err, 1);

    // Good frame under continuous CON reads: rx_done holds
    Address = CON;
    MemRd   = 1'b1;
    send_rx(8'h55, 1'b1, 1'b1);
    MemRd = 1'b0;
    check("rxdone_during_con_rd", seen_done, 1'b1);
    peek(CON, d);
    check("rxdone_after_con_rd", d, 32'h08);
    bus_read(RXD, d);
    check("rxd_55", d, 32'h55);

    // Randomized concurrent TX/RX
    pulse_reset();
    run_random(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
